// File: rtl/kofn_threshold_detector_if.sv
// -----------------------------------------------------------------------------
// kofn_threshold_detector_if
//
// Purpose: groups the control, data and status signals of the
// "at least K of N" threshold detector into a single bundle.
//
// Parameters:
//   N_IN   number of switch channels
//   CW     width of the popcount / threshold fields
//   CNT_W  width of the event counter
//
// Signals:
//   en           sampling enable (prescaler and debounce run while high)
//   din          raw asynchronous switch inputs
//   threshold    K, compared against the debounced popcount
//   clear        synchronous clear of the event counter (and sticky match)
//   popcount     number of debounced inputs that are high
//   match        popcount >= threshold
//   match_rise   one-cycle pulse on a 0->1 transition of match
//   event_count  saturating count of match_rise pulses
//   tick         one-cycle pulse at each debounce sample point
//
// Modports:
//   master  drives en/din/threshold/clear, observes the status outputs
//   slave   the detector itself
// -----------------------------------------------------------------------------
interface kofn_threshold_detector_if #(
    parameter int N_IN  = 8,
    parameter int CW    = $clog2(N_IN + 1),
    parameter int CNT_W = 8
);
    logic              en;
    logic [N_IN-1:0]   din;
    logic [CW-1:0]     threshold;
    logic              clear;
    logic [CW-1:0]     popcount;
    logic              match;
    logic              match_rise;
    logic [CNT_W-1:0]  event_count;
    logic              tick;

    modport master (
        output en, din, threshold, clear,
        input  popcount, match, match_rise, event_count, tick
    );

    modport slave (
        input  en, din, threshold, clear,
        output popcount, match, match_rise, event_count, tick
    );
endinterface

// File: rtl/kofn_threshold_detector.sv
// -----------------------------------------------------------------------------
// kofn_threshold_detector
//
// Purpose: synchronises and debounces N_IN switch inputs, counts how many of
// the debounced inputs are high and flags when that count reaches a runtime
// threshold K ("at least K of N"). Rising edges of the flag are counted in a
// saturating event counter for display.
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   asynchronous, active-high reset
//   bus   kofn_threshold_detector_if.slave (en, din, threshold, clear in;
//         popcount, match, match_rise, event_count, tick out)
//
// Optional feature:
//   KOFN_STICKY_MATCH_EN  when defined, match latches high once the compare
//                         is true and holds until clear or rst; match_rise
//                         then marks only the latched 0->1 transition.
//                         When undefined, match follows the compare.
// -----------------------------------------------------------------------------
module kofn_threshold_detector #(
    parameter int N_IN        = 8,
    parameter int TICK_DIV    = 10_000_000,
    parameter int DEB_SAMPLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    kofn_threshold_detector_if.slave      bus
);

    localparam int CW = $clog2(N_IN + 1);
    // Prescaler and debounce counter widths; never narrower than one bit.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES + 1) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_SAMPLES - 1);
    localparam logic [CNT_W-1:0] EVT_MAX    = {CNT_W{1'b1}};

    // Number of set bits in the debounced vector.
    function automatic logic [CW-1:0] count_ones(input logic [N_IN-1:0] v);
        logic [CW-1:0] sum;
        sum = {CW{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            sum = sum + CW'(v[i]);
        end
        return sum;
    endfunction

    // Two-flop synchroniser.
    logic [N_IN-1:0]          sync1_q, sync1_d;
    logic [N_IN-1:0]          sync2_q, sync2_d;
    // Prescaler.
    logic [PW-1:0]            presc_q, presc_d;
    logic                     tick_s;
    // Debounce state.
    logic [N_IN-1:0]          deb_q, deb_d;
    logic [N_IN-1:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
    // Compare / event path.
    logic [CW-1:0]            popcount_q, popcount_d;
    logic                     cmp_s;
    logic                     match_q, match_d;
    logic                     match_rise_q, match_rise_d;
    logic [CNT_W-1:0]         event_count_q, event_count_d;

    // Synchroniser next state: shift the raw inputs through two stages.
    always_comb begin
        sync1_d = bus.din;
        sync2_d = sync1_q;
    end

    // Prescaler next state and sample tick; en low freezes the count.
    always_comb begin
        presc_d = presc_q;
        tick_s  = 1'b0;
        if (bus.en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = {PW{1'b0}};
                tick_s  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
                tick_s  = 1'b0;
            end
        end else begin
            presc_d = presc_q;
            tick_s  = 1'b0;
        end
    end

    // Per-channel debounce: a change is accepted after DEB_SAMPLES
    // consecutive differing ticks; any agreeing tick restarts the count.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int ch = 0; ch < N_IN; ch++) begin
            if (tick_s) begin
                if (sync2_q[ch] != deb_q[ch]) begin
                    if (deb_cnt_q[ch] == DEB_LAST) begin
                        deb_d[ch]     = sync2_q[ch];
                        deb_cnt_d[ch] = {DW{1'b0}};
                    end else begin
                        deb_cnt_d[ch] = deb_cnt_q[ch] + DW'(1);
                    end
                end else begin
                    deb_cnt_d[ch] = {DW{1'b0}};
                end
            end else begin
                deb_cnt_d[ch] = deb_cnt_q[ch];
            end
        end
    end

    // Popcount, threshold compare, match and its rising-edge pulse.
    always_comb begin
        popcount_d = count_ones(deb_q);
        cmp_s      = (popcount_q >= bus.threshold);
`ifdef KOFN_STICKY_MATCH_EN
        // Latched flag: set by the compare, dropped only by clear.
        if (bus.clear) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q | cmp_s;
        end
`else
        match_d = cmp_s;
`endif
        match_rise_d = match_d & ~match_q;
    end

    // Saturating event counter; clear takes priority over an increment.
    always_comb begin
        event_count_d = event_count_q;
        if (bus.clear) begin
            event_count_d = {CNT_W{1'b0}};
        end else if (match_rise_q && (event_count_q != EVT_MAX)) begin
            event_count_d = event_count_q + CNT_W'(1);
        end else begin
            event_count_d = event_count_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= {N_IN{1'b0}};
            sync2_q       <= {N_IN{1'b0}};
            presc_q       <= {PW{1'b0}};
            deb_q         <= {N_IN{1'b0}};
            deb_cnt_q     <= '0;
            popcount_q    <= {CW{1'b0}};
            match_q       <= 1'b0;
            match_rise_q  <= 1'b0;
            event_count_q <= {CNT_W{1'b0}};
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            presc_q       <= presc_d;
            deb_q         <= deb_d;
            deb_cnt_q     <= deb_cnt_d;
            popcount_q    <= popcount_d;
            match_q       <= match_d;
            match_rise_q  <= match_rise_d;
            event_count_q <= event_count_d;
        end
    end

    // Output drive.
    assign bus.popcount    = popcount_q;
    assign bus.match       = match_q;
    assign bus.match_rise  = match_rise_q;
    assign bus.event_count = event_count_q;
    assign bus.tick        = tick_s;

endmodule

// File: tb/tb_kofn_threshold_detector.sv
// -----------------------------------------------------------------------------
// tb_kofn_threshold_detector
//
// Directed bench for kofn_threshold_detector. Two instances share clk/rst:
// u_dut1 (TICK_DIV=1) for the main function and u_dut5 (TICK_DIV=5) for the
// prescaler / enable behaviour. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_kofn_threshold_detector;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   rises;

    kofn_threshold_detector_if #(.N_IN(8), .CW(4), .CNT_W(8)) if1 ();
    kofn_threshold_detector_if #(.N_IN(8), .CW(4), .CNT_W(8)) if5 ();

    kofn_threshold_detector #(
        .N_IN(8), .TICK_DIV(1), .DEB_SAMPLES(4), .CNT_W(8)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    kofn_threshold_detector #(
        .N_IN(8), .TICK_DIV(5), .DEB_SAMPLES(4), .CNT_W(8)
    ) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (if5)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rises    = 0;
        rst      = 1'b1;
        if1.en = 1'b1; if1.din = 8'h00; if1.threshold = 4'd3; if1.clear = 1'b0;
        if5.en = 1'b1; if5.din = 8'hFF; if5.threshold = 4'd1; if5.clear = 1'b0;
        step(3);

        // ---- 1: reset state and tick every cycle ----------------------------
        check("rst_popcount", 32'(if1.popcount), 32'd0);
        check("rst_match", 32'(if1.match), 32'd0);
        check("rst_match_rise", 32'(if1.match_rise), 32'd0);
        check("rst_event_count", 32'(if1.event_count), 32'd0);
        check("rst_popcount5", 32'(if5.popcount), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t1_tick", 32'(if1.tick), 32'd1);
            check("t1_match", 32'(if1.match), 32'd0);
            check("t1_popcount", 32'(if1.popcount), 32'd0);
        end

        // ---- 2: din 0x00 -> 0x07, latency 2+4+2 -----------------------------
        if1.din = 8'h07;
        step(6);
        check("t2_popcount_early", 32'(if1.popcount), 32'd0);
        step(1);
        check("t2_popcount", 32'(if1.popcount), 32'd3);
        check("t2_match_early", 32'(if1.match), 32'd0);
        step(1);
        check("t2_match", 32'(if1.match), 32'd1);
        check("t2_match_rise", 32'(if1.match_rise), 32'd1);
        step(1);
        check("t2_match_rise_end", 32'(if1.match_rise), 32'd0);
        check("t2_event_count", 32'(if1.event_count), 32'd1);

        // Reset mid-operation clears everything immediately.
        #3;
        rst = 1'b1;
        #1;
        check("midrst_popcount", 32'(if1.popcount), 32'd0);
        check("midrst_match", 32'(if1.match), 32'd0);
        check("midrst_event_count", 32'(if1.event_count), 32'd0);
        @(posedge clk);
        #1;
        if1.din = 8'h00;
        if1.threshold = 4'd1;
        apply_reset();

        // ---- 3: 3-tick glitch rejected, 4-tick pulse accepted ---------------
        if1.din = 8'h01;
        step(3);
        if1.din = 8'h00;
        rises = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            rises += int'(if1.match_rise);
        end
        check("t3_glitch_popcount", 32'(if1.popcount), 32'd0);
        check("t3_glitch_match", 32'(if1.match), 32'd0);
        check("t3_glitch_rises", 32'(rises), 32'd0);

        if1.din = 8'h01;
        step(4);
        if1.din = 8'h00;
        step(2);
        check("t3_pulse_popcount_early", 32'(if1.popcount), 32'd0);
        step(1);
        check("t3_pulse_popcount", 32'(if1.popcount), 32'd1);
        check("t3_pulse_match_early", 32'(if1.match), 32'd0);
        step(1);
        check("t3_pulse_match", 32'(if1.match), 32'd1);
        rises = 1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            rises += int'(if1.match_rise);
        end
        check("t3_pulse_rises", 32'(rises), 32'd1);
        check("t3_pulse_popcount_back", 32'(if1.popcount), 32'd0);
`ifdef KOFN_STICKY_MATCH_EN
        check("t3_sticky_match_held", 32'(if1.match), 32'd1);
`else
        check("t3_match_follows", 32'(if1.match), 32'd0);
`endif

        // ---- 4: saturation and clear priority (or sticky clear) -------------
        if1.threshold = 4'd1;
        apply_reset();
`ifndef KOFN_STICKY_MATCH_EN
        for (int i = 0; i < 260; i++) begin
            if1.threshold = 4'd0;
            step(2);
            if1.threshold = 4'd1;
            step(2);
        end
        check("t4_saturated", 32'(if1.event_count), 32'd255);
        if1.threshold = 4'd0;
        step(1);
        check("t4_rise_with_clear", 32'(if1.match_rise), 32'd1);
        if1.clear = 1'b1;
        step(1);
        check("t4_clear_wins_sat", 32'(if1.event_count), 32'd0);
        if1.clear = 1'b0;
        if1.threshold = 4'd1;
        step(2);
        if1.threshold = 4'd0;
        step(2);
        check("t4_count_after_clear", 32'(if1.event_count), 32'd1);
        if1.threshold = 4'd1;
        step(2);
        if1.threshold = 4'd0;
        step(1);
        if1.clear = 1'b1;
        step(1);
        check("t4_clear_wins_inc", 32'(if1.event_count), 32'd0);
        if1.clear = 1'b0;
        step(1);
        check("t4_clear_hold", 32'(if1.event_count), 32'd0);
`else
        if1.din = 8'h01;
        step(8);
        check("t4s_match_set", 32'(if1.match), 32'd1);
        if1.din = 8'h00;
        step(12);
        check("t4s_popcount_zero", 32'(if1.popcount), 32'd0);
        check("t4s_match_held", 32'(if1.match), 32'd1);
        check("t4s_event_count", 32'(if1.event_count), 32'd1);
        if1.clear = 1'b1;
        step(1);
        check("t4s_match_cleared", 32'(if1.match), 32'd0);
        check("t4s_event_cleared", 32'(if1.event_count), 32'd0);
        if1.clear = 1'b0;
        step(1);
        check("t4s_match_reeval", 32'(if1.match), 32'd0);
        check("t4s_no_rise", 32'(if1.match_rise), 32'd0);
`endif

        // ---- 5: threshold=0 and threshold>N_IN ------------------------------
        rst = 1'b1;
        if1.din = 8'h00;
        if1.threshold = 4'd0;
        step(2);
        rst = 1'b0;
        step(1);
        check("t5_thr0_match", 32'(if1.match), 32'd1);
        check("t5_thr0_rise", 32'(if1.match_rise), 32'd1);
        step(1);
        check("t5_thr0_rise_end", 32'(if1.match_rise), 32'd0);
        check("t5_thr0_event", 32'(if1.event_count), 32'd1);
        rst = 1'b1;
        if1.din = 8'hFF;
        if1.threshold = 4'd9;
        step(2);
        rst = 1'b0;
        step(14);
        check("t5_thr9_popcount", 32'(if1.popcount), 32'd8);
        check("t5_thr9_match", 32'(if1.match), 32'd0);
        check("t5_thr9_event", 32'(if1.event_count), 32'd0);

        // ---- 6: TICK_DIV=5, enable freeze and resume ------------------------
        if5.en = 1'b1;
        apply_reset();
        step(2);
        check("t6_tick_pre", 32'(if5.tick), 32'd0);
        if5.en = 1'b0;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            rises += int'(if5.tick);
        end
        check("t6_frozen_ticks", 32'(rises), 32'd0);
        check("t6_frozen_popcount", 32'(if5.popcount), 32'd0);
        if5.en = 1'b1;
        step(1);
        check("t6_resume_tick0", 32'(if5.tick), 32'd0);
        step(1);
        check("t6_resume_tick1", 32'(if5.tick), 32'd1);
        step(1);
        check("t6_resume_tick2", 32'(if5.tick), 32'd0);
        step(15);
        check("t6_popcount_early", 32'(if5.popcount), 32'd0);
        step(1);
        check("t6_popcount", 32'(if5.popcount), 32'd8);
        check("t6_match_early", 32'(if5.match), 32'd0);
        step(1);
        check("t6_match", 32'(if5.match), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
